mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch and data load/store requesters of `riscv_wrapper`. Serializes one transaction at a time through a three-state FSM, routes the read data back to the owning requester and alternates grants when both sides contend. A watchdog terminates any transaction the memory never acknowledges, so the core sees an error instead of a hang, which it can raise as `trap`.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` wide.
- `TIMEOUT`, 15: maximum cycles in BUSY without `mem_ready` before an error completion; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_done`.
- `i_addr`  in  ADDR_W  fetch address (always a read).
- `i_done`  out  1  one-cycle completion pulse to fetch.
- `i_rdata`  out  DATA_W  fetch data; valid while `i_done`=1.
- `d_req`  in  1  load/store request; attributes held until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  DATA_W/8  store byte enables.
- `d_addr`  in  ADDR_W  load/store address.
- `d_wdata`  in  DATA_W  store data.
- `d_done`  out  1  one-cycle completion pulse to load/store.
- `d_rdata`  out  DATA_W  load data; valid while `d_done`=1.
- `err`  out  1  asserted together with a done pulse when that transaction timed out.
- `mem_req`  out  1  memory request, registered.
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  —  registered transaction attributes, stable while `mem_req`=1.
- `mem_ready`  in  1  memory acknowledge; for reads `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- State machine: IDLE, BUSY, RESP.
- **IDLE.**
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both `i_req` and `d_req`: grant the requester not granted last (`last_gnt`).
  - On grant: latch owner, address, write enable, byte enables and write data into the `mem_*` registers; set `mem_req`=1; clear the watchdog; go to BUSY.
  - Fetch grants drive `mem_we`=0 and `mem_be`=all ones.
- **BUSY.**
  - `mem_req` held at 1 with attributes unchanged.
  - On `mem_ready`=1: register `mem_rdata` into the owner's rdata; drop `mem_req`; go to RESP with the owner's done flag set and `err`=0.
  - Otherwise the watchdog increments. When it reaches `TIMEOUT`: drop `mem_req`; set the owner's rdata to 0; go to RESP with the owner's done flag set and `err`=1.
- **RESP.**
  - The owner's done is high for exactly this one cycle.
  - Update `last_gnt` to the owner; return to IDLE.
  - `*_req` inputs are ignored in this state.
- Requester rule: deassert req, or present a new request, in the cycle after its done. The arbiter samples req again in IDLE, one cycle after RESP, so a finished request is never reissued.
- Store completions also load `d_rdata` from `mem_rdata`; consumers ignore `d_rdata` on stores.
- Watchdog width is 8 bits and it never wraps; `TIMEOUT`=1 means error on the first BUSY cycle without ready.
- Reset values: every output 0, state IDLE, watchdog 0, `last_gnt`=fetch (so the first tie goes to load/store).
- Reset asserted mid-transaction: `mem_req` and any done pulse drop immediately (asynchronously), with no done pulse afterwards. Requesters re-present their requests after reset releases.

## Timing
- Request high in IDLE at edge 0 → `mem_req`=1 after edge 0.
- `mem_ready` sampled at edge k → done=1 after edge k, for one cycle → IDLE after edge k+1.
- Minimum transaction, with ready in the first BUSY cycle: 3 cycles request-to-IDLE. Throughput is one transaction per 3 cycles.
- Timeout: done and `err` appear after the TIMEOUT-th BUSY edge without ready.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- **Reset:** hold `reset`=0, toggle every input → all outputs 0. Release at 16 ns; first edge with state IDLE.
- **Single fetch:** `i_req`=1, `i_addr`=0x0000_0010; memory returns ready on the first BUSY cycle with `mem_rdata`=0x0050_0093 → `mem_req` for 1 cycle, `mem_we`=0, `mem_be`=0xF, then `i_done`=1 and `i_rdata`=0x0050_0093 for 1 cycle, `err`=0.
- **Contention:** `i_req` and `d_req` both held through four transactions → grant order D, I, D, I. Each done is exactly one cycle, and no transaction is issued twice.
- **Store:** `d_we`=1, `d_be`=0x3, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF; ready after 3 wait cycles → `mem_*` stable for 4 cycles, then `d_done`=1 one cycle later.
- **Timeout:** `TIMEOUT`=15 with `mem_ready` tied 0 → `mem_req` high for 15 cycles, then `d_done`=1, `err`=1, `d_rdata`=0. The FSM then returns to IDLE and the next request is served normally.
- **Reset mid-BUSY:** pull `reset` low two cycles into a wait-stated read → `mem_req` falls without waiting for a clock edge, and no done pulse appears after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction at a time, alternating grants, watchdog-terminated.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] WDOG_MAX = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // owner / last_gnt encoding: 1 = load/store, 0 = fetch
    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_gnt_q, last_gnt_d;
    logic [7:0]          wdog_q, wdog_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                gnt_data;
    logic [7:0]          wdog_inc;

    // Tie goes to whoever was not served last.
    always_comb begin
        gnt_data = d_req && (!i_req || !last_gnt_q);
        wdog_inc = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        wdog_d      = wdog_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d   = gnt_data;
                    mem_req_d = 1'b1;
                    wdog_d    = 8'd0;
                    state_d   = BUSY;
                    if (gnt_data) begin
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (owner_q) begin
                        d_rdata_d = mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_done_d  = 1'b1;
                    end
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc >= WDOG_MAX) begin
                        mem_req_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = RESP;
                        if (owner_q) begin
                            d_rdata_d = '0;
                            d_done_d  = 1'b1;
                        end else begin
                            i_rdata_d = '0;
                            i_done_d  = 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                last_gnt_d = owner_q;
                state_d    = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'b0;
            wdog_q      <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            wdog_q      <= wdog_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_done    = i_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of grants and results.
module tb_mem_port_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    bit model_last;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory-side driver: waits for a request, answers after wait_n
    // wait cycles (never if wait_n is huge), reports what it saw.
    task automatic serve(input int wait_n, input logic [31:0] rd,
                         output bit seen, output int reqc, output bit stable,
                         output logic we, output logic [3:0] be,
                         output logic [31:0] addr, output logic [31:0] wdata,
                         output logic di, output logic dd, output logic e,
                         output logic [31:0] ri, output logic [31:0] rdd);
        bit fin;
        int waits;
        seen = 0; reqc = 0; stable = 1; fin = 0; waits = 0;
        we = 0; be = 0; addr = 0; wdata = 0;
        di = 0; dd = 0; e = 0; ri = 0; rdd = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (mem_req === 1'b1) seen = 1;
        end
        if (!seen) return;
        we = mem_we; be = mem_be; addr = mem_addr; wdata = mem_wdata;
        for (int t = 0; t < 400 && !fin; t++) begin
            if (mem_req === 1'b1) begin
                reqc++;
                if (mem_we !== we || mem_be !== be ||
                    mem_addr !== addr || mem_wdata !== wdata) stable = 0;
                mem_ready = (waits == wait_n);
                mem_rdata = (waits == wait_n) ? rd : ~rd;
                waits++;
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            if (i_done === 1'b1 || d_done === 1'b1) begin
                fin = 1;
                di = i_done; dd = d_done; e = err;
                ri = i_rdata; rdd = d_rdata;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [135:0] outs;
        reset = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
        d_be = 0; d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
        for (int k = 0; k < 3; k++) begin
            #4;
            i_req = 1'($urandom); i_addr = $urandom; d_req = 1'($urandom);
            d_we = 1'($urandom); d_be = 4'($urandom); d_addr = $urandom;
            d_wdata = $urandom; mem_ready = 1'($urandom); mem_rdata = $urandom;
            #0;
            outs = {i_done, i_rdata, d_done, d_rdata, err, mem_req,
                    mem_we, mem_be, mem_addr[31:0], mem_wdata[31:0]};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outs[%0d] got %h want 0", k, outs);
            end
        end
        #4;
        reset = 1'b1; i_req = 0; d_req = 0; mem_ready = 0;
        @(negedge clk);
        checks++;
        if ({mem_req, i_done, d_done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release got %b want 0000",
                     {mem_req, i_done, d_done, err});
        end
        model_last = 1'b0;
    endtask

    task automatic test_single_fetch();
        bit s, st; int rc; logic we, di, dd, e;
        logic [3:0] be; logic [31:0] a, wd, ri, rdd;
        i_req = 1; i_addr = 32'h0000_0010;
        serve(0, 32'h0050_0093, s, rc, st, we, be, a, wd, di, dd, e, ri, rdd);
        i_req = 0;
        checks++;
        if (!s || rc != 1) begin
            errors++;
            $display("FAIL fetch_req_cycles got %0d want 1", rc);
        end
        checks++;
        if ({we, be, a} !== {1'b0, 4'hF, 32'h10}) begin
            errors++;
            $display("FAIL fetch_attrs got %b %h %h want 0 f 10", we, be, a);
        end
        checks++;
        if ({di, dd, e, ri} !== {3'b100, 32'h0050_0093}) begin
            errors++;
            $display("FAIL fetch_done got %b%b%b %h want 100 00500093",
                     di, dd, e, ri);
        end
        @(negedge clk);
        checks++;
        if ({i_done, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_one_cycle got %b want 00", {i_done, mem_req});
        end
        model_last = 1'b0;
    endtask

    task automatic test_contention();
        bit s, st; int rc; logic we, di, dd, e, exp_d;
        logic [3:0] be; logic [31:0] a, wd, ri, rdd, rd;
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_addr = 32'h300; d_we = 0; d_be = 4'hF; d_wdata = 0;
        for (int k = 0; k < 4; k++) begin
            exp_d = !model_last;
            rd = 32'hA000_0000 + 32'(k);
            serve(k % 2, rd, s, rc, st, we, be, a, wd, di, dd, e, ri, rdd);
            checks++;
            if ({dd, di} !== {exp_d, !exp_d} ||
                a !== (exp_d ? 32'h300 : 32'h200)) begin
                errors++;
                $display("FAIL contention_grant[%0d] got d=%b i=%b a=%h want d=%b",
                         k, dd, di, a, exp_d);
            end
            checks++;
            if ((exp_d ? rdd : ri) !== rd || e !== 1'b0) begin
                errors++;
                $display("FAIL contention_data[%0d] got %h err=%b want %h",
                         k, exp_d ? rdd : ri, e, rd);
            end
            model_last = exp_d;
            @(negedge clk);
            checks++;
            if ({i_done, d_done, mem_req} !== 3'b000) begin
                errors++;
                $display("FAIL contention_gap[%0d] got %b want 000",
                         k, {i_done, d_done, mem_req});
            end
        end
        i_req = 0; d_req = 0;
    endtask

    task automatic test_store();
        bit s, st; int rc; logic we, di, dd, e;
        logic [3:0] be; logic [31:0] a, wd, ri, rdd;
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        serve(3, 32'h1234_5678, s, rc, st, we, be, a, wd, di, dd, e, ri, rdd);
        d_req = 0; d_we = 0;
        checks++;
        if (rc != 4 || !st) begin
            errors++;
            $display("FAIL store_req_cycles got %0d stable=%b want 4 1", rc, st);
        end
        checks++;
        if ({we, be, a, wd} !== {1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_attrs got %b %h %h %h", we, be, a, wd);
        end
        checks++;
        if ({di, dd, e, rdd} !== {3'b010, 32'h1234_5678}) begin
            errors++;
            $display("FAIL store_done got %b%b%b %h want 010 12345678",
                     di, dd, e, rdd);
        end
        model_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit s, st; int rc; logic we, di, dd, e;
        logic [3:0] be; logic [31:0] a, wd, ri, rdd;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h44;
        serve(100000, 32'h5555_AAAA, s, rc, st, we, be, a, wd,
              di, dd, e, ri, rdd);
        d_req = 0;
        checks++;
        if (rc != TO) begin
            errors++;
            $display("FAIL timeout_req_cycles got %0d want %0d", rc, TO);
        end
        checks++;
        if ({di, dd, e, rdd} !== {3'b011, 32'h0}) begin
            errors++;
            $display("FAIL timeout_done got %b%b%b %h want 011 0",
                     di, dd, e, rdd);
        end
        model_last = 1'b1;
        @(negedge clk);
        checks++;
        if ({d_done, err} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse got %b want 00", {d_done, err});
        end
        i_req = 1; i_addr = 32'h48;
        serve(1, 32'hCAFE_0001, s, rc, st, we, be, a, wd, di, dd, e, ri, rdd);
        i_req = 0;
        checks++;
        if ({di, dd, e, ri, rc} !== {3'b100, 32'hCAFE_0001, 32'd2}) begin
            errors++;
            $display("FAIL timeout_recover got %b%b%b %h rc=%0d",
                     di, dd, e, ri, rc);
        end
        model_last = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit s, st, pi, pd, tmo; int rc, wn; logic we, di, dd, e, exp_d;
        logic [3:0] be, dbe; logic [31:0] a, wd, ri, rdd, rd;
        logic [31:0] ia, da, dwd; logic dwe;
        pi = 0; pd = 0; ia = 0; da = 0; dwd = 0; dwe = 0; dbe = 0;
        for (int k = 0; k < 30; k++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1; ia = $urandom;
            end
            if (!pd && ($urandom_range(0, 1) == 1 || !pi)) begin
                pd = 1; da = $urandom; dwe = 1'($urandom);
                dbe = 4'($urandom); dwd = $urandom;
            end
            i_req = pi; i_addr = ia;
            d_req = pd; d_addr = da; d_we = dwe; d_be = dbe; d_wdata = dwd;
            exp_d = pd && (!pi || !model_last);
            tmo = ($urandom_range(0, 7) == 0);
            wn = tmo ? 100000 : int'($urandom_range(0, 4));
            rd = $urandom;
            serve(wn, rd, s, rc, st, we, be, a, wd, di, dd, e, ri, rdd);
            checks++;
            if ({dd, di} !== {exp_d, !exp_d} ||
                a !== (exp_d ? da : ia) ||
                we !== (exp_d ? dwe : 1'b0) ||
                be !== (exp_d ? dbe : 4'hF) ||
                (exp_d && wd !== dwd) || !st) begin
                errors++;
                $display("FAIL rand_grant[%0d] got d=%b a=%h we=%b be=%h wd=%h",
                         k, dd, a, we, be, wd);
            end
            checks++;
            if (rc != (tmo ? TO : wn + 1) || e !== tmo ||
                (exp_d ? rdd : ri) !== (tmo ? 32'h0 : rd)) begin
                errors++;
                $display("FAIL rand_result[%0d] got rc=%0d err=%b data=%h want err=%b",
                         k, rc, e, exp_d ? rdd : ri, tmo);
            end
            model_last = exp_d;
            if (exp_d) begin pd = 0; d_req = 0; end
            else begin pi = 0; i_req = 0; end
            @(negedge clk);
            checks++;
            if ({i_done, d_done, err, mem_req} !== 4'b0) begin
                errors++;
                $display("FAIL rand_gap[%0d] got %b want 0000",
                         k, {i_done, d_done, err, mem_req});
            end
        end
        i_req = 0; d_req = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        bit s, st; int rc, bad; logic we, di, dd, e;
        logic [3:0] be; logic [31:0] a, wd, ri, rdd;
        i_req = 1; i_addr = 32'h80; mem_ready = 0;
        s = 0;
        for (int t = 0; t < 20 && !s; t++) begin
            @(negedge clk);
            if (mem_req === 1'b1) s = 1;
        end
        checks++;
        if (!s) begin
            errors++;
            $display("FAIL rst_busy_start got mem_req=%b want 1", mem_req);
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, i_done, d_done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async_drop got %b want 000",
                     {mem_req, i_done, d_done});
        end
        i_req = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (i_done !== 1'b0 || d_done !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_done got %0d bad cycles want 0", bad);
        end
        model_last = 1'b0;
        i_req = 1; i_addr = 32'h90;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h94;
        serve(0, 32'h0BAD_F00D, s, rc, st, we, be, a, wd, di, dd, e, ri, rdd);
        d_req = 0;
        checks++;
        if ({dd, di, a, rdd} !== {2'b10, 32'h94, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL rst_first_tie got d=%b i=%b a=%h %h want d=1 a=94",
                     dd, di, a, rdd);
        end
        i_req = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_random();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
